// File: rtl/network_interface_if.sv
// Bundles the PE-side and router-side ports of network_interface.
// Valid/ready: a flit moves on every rising edge where both valid and ready are high; valid must not wait on ready.
interface network_interface_if #(
    parameter int FLIT_W = 20,
    parameter int CNT_W  = 16
);
    logic [FLIT_W-1:0] pe_tx_flit;
    logic              pe_tx_valid;
    logic              pe_tx_ready;
    logic [FLIT_W-1:0] pe_rx_flit;
    logic              pe_rx_valid;
    logic              pe_rx_ready;
    logic [FLIT_W-1:0] net_o;
    logic              net_vo;
    logic              net_ci;
    logic [FLIT_W-1:0] net_i;
    logic              net_vi;
    logic              net_co;
    logic              overflow;
    logic [CNT_W-1:0]  tx_count;
    logic [CNT_W-1:0]  rx_count;

    modport slave (
        input  pe_tx_flit, pe_tx_valid, output pe_tx_ready,
        output pe_rx_flit, pe_rx_valid, input  pe_rx_ready,
        output net_o, net_vo, input net_ci,
        input  net_i, net_vi, output net_co,
        output overflow, tx_count, rx_count
    );

    modport master (
        output pe_tx_flit, pe_tx_valid, input  pe_tx_ready,
        input  pe_rx_flit, pe_rx_valid, output pe_rx_ready,
        input  net_o, net_vo, output net_ci,
        output net_i, net_vi, input  net_co,
        input  overflow, tx_count, rx_count
    );
endinterface

// File: rtl/network_interface.sv
// NoC network interface: credit-based inject path toward the router, buffered eject path toward the PE.
module network_interface #(
    parameter int FLIT_W    = 20,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int CREDITS   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    network_interface_if.slave               bus,
    output logic [$clog2(CREDITS+1)-1:0]     credit_count
);
    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam int CW  = $clog2(CREDITS + 1);

    // ---------------- inject path ----------------
    logic [FLIT_W-1:0] inj_mem [INJ_DEPTH];
    logic [IAW:0]      inj_wr;
    logic [IAW:0]      inj_rd;
    logic              inj_empty;
    logic              inj_full;
    logic              push_tx;
    logic              send;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     credit_next;
    logic [FLIT_W-1:0] net_o_q;
    logic              net_vo_q;
    logic [CNT_W-1:0]  tx_cnt;

    assign inj_empty       = (inj_wr == inj_rd);
    assign inj_full        = (inj_wr[IAW] != inj_rd[IAW]) && (inj_wr[IAW-1:0] == inj_rd[IAW-1:0]);
    assign push_tx         = bus.pe_tx_valid && !inj_full;
    assign send            = !inj_empty && (credit != '0);
    assign bus.pe_tx_ready = !inj_full;

    always_ff @(posedge clk) begin
        if (push_tx) inj_mem[inj_wr[IAW-1:0]] <= bus.pe_tx_flit;
    end

    // A credit coinciding with a send cancels out; credits beyond CREDITS are ignored.
    always_comb begin
        credit_next = credit;
        unique case ({send, bus.net_ci})
            2'b10:   credit_next = credit - 1'b1;
            2'b01:   if (credit != CW'(CREDITS)) credit_next = credit + 1'b1;
            default: credit_next = credit;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_wr   <= '0;
            inj_rd   <= '0;
            credit   <= CW'(CREDITS);
            net_o_q  <= '0;
            net_vo_q <= 1'b0;
            tx_cnt   <= '0;
        end else begin
            credit   <= credit_next;
            net_vo_q <= send;
            if (push_tx) inj_wr <= inj_wr + 1'b1;
            if (send) begin
                inj_rd  <= inj_rd + 1'b1;
                net_o_q <= inj_mem[inj_rd[IAW-1:0]];
                tx_cnt  <= tx_cnt + 1'b1;
            end
        end
    end

    assign bus.net_o    = net_o_q;
    assign bus.net_vo   = net_vo_q;
    assign bus.tx_count = tx_cnt;
    assign credit_count = credit;

    // ---------------- eject path ----------------
    logic [FLIT_W-1:0] ej_mem [EJ_DEPTH];
    logic [EAW:0]      ej_wr;
    logic [EAW:0]      ej_rd;
    logic              ej_empty;
    logic              ej_full;
    logic              pop;
    logic              accept;
    logic              drop;
    logic              net_co_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  rx_cnt;

    assign ej_empty = (ej_wr == ej_rd);
    assign ej_full  = (ej_wr[EAW] != ej_rd[EAW]) && (ej_wr[EAW-1:0] == ej_rd[EAW-1:0]);
    assign pop      = !ej_empty && bus.pe_rx_ready;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign accept   = bus.net_vi && (!ej_full || pop);
    assign drop     = bus.net_vi && ej_full && !pop;

    always_ff @(posedge clk) begin
        if (accept) ej_mem[ej_wr[EAW-1:0]] <= bus.net_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_wr      <= '0;
            ej_rd      <= '0;
            net_co_q   <= 1'b0;
            overflow_q <= 1'b0;
            rx_cnt     <= '0;
        end else begin
            net_co_q <= pop;
            if (accept) begin
                ej_wr  <= ej_wr + 1'b1;
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (pop)  ej_rd      <= ej_rd + 1'b1;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign bus.pe_rx_flit  = ej_mem[ej_rd[EAW-1:0]];
    assign bus.pe_rx_valid = !ej_empty;
    assign bus.net_co      = net_co_q;
    assign bus.overflow    = overflow_q;
    assign bus.rx_count    = rx_cnt;
endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface: expected flits queued at stimulus time, checked by a monitor.
module tb_network_interface;
    localparam int FLIT_W = 20;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] credit_count;

    always #5 clk = ~clk;

    network_interface_if #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) bus ();

    network_interface #(
        .FLIT_W(FLIT_W), .INJ_DEPTH(4), .EJ_DEPTH(4), .CREDITS(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .credit_count(credit_count)
    );

    logic [FLIT_W-1:0] exp_net_q[$];
    logic [FLIT_W-1:0] exp_rx_q[$];
    int total = 0;
    int bad = 0;
    int net_pulses = 0;
    int co_pulses = 0;
    logic prev_pop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [FLIT_W-1:0] f);
        int n = 0;
        bus.pe_tx_flit  = f;
        bus.pe_tx_valid = 1'b1;
        while (!bus.pe_tx_ready && n < 50) begin
            cyc();
            n++;
        end
        if (!bus.pe_tx_ready) check("tx_ready_timeout", 32'd0, 32'd1);
        else begin
            exp_net_q.push_back(f);
            cyc();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pe_tx_ready"}, 32'(bus.pe_tx_ready), 32'd1);
        check({tag, "_pe_rx_valid"}, 32'(bus.pe_rx_valid), 32'd0);
        check({tag, "_net_vo"},      32'(bus.net_vo),      32'd0);
        check({tag, "_net_o"},       32'(bus.net_o),       32'd0);
        check({tag, "_net_co"},      32'(bus.net_co),      32'd0);
        check({tag, "_overflow"},    32'(bus.overflow),    32'd0);
        check({tag, "_tx_count"},    32'(bus.tx_count),    32'd0);
        check({tag, "_rx_count"},    32'(bus.rx_count),    32'd0);
        check({tag, "_credits"},     32'(credit_count),    32'd4);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_net_q.delete();
        exp_rx_q.delete();
        repeat (2) cyc();
        check_reset_vals("rst");
        rst = 1'b1;
    endtask

    // Monitor: compares every presented flit against the queues and times net_co against pops.
    always @(negedge clk) begin
        if (!rst) prev_pop = 1'b0;
        else begin
            logic pop_now;
            if (bus.net_vo) begin
                net_pulses++;
                if (exp_net_q.size() == 0) check("net_unexpected", 32'd1, 32'd0);
                else check("net_flit", 32'(bus.net_o), 32'(exp_net_q.pop_front()));
            end
            if (bus.net_co || prev_pop) check("net_co_timing", 32'(bus.net_co), 32'(prev_pop));
            if (bus.net_co) co_pulses++;
            pop_now = bus.pe_rx_valid && bus.pe_rx_ready;
            if (pop_now) begin
                if (exp_rx_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else check("rx_flit", 32'(bus.pe_rx_flit), 32'(exp_rx_q.pop_front()));
            end
            prev_pop = pop_now;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int c0;
        bus.pe_tx_flit  = '0;
        bus.pe_tx_valid = 1'b0;
        bus.pe_rx_ready = 1'b0;
        bus.net_ci      = 1'b0;
        bus.net_i       = '0;
        bus.net_vi      = 1'b0;

        // First flit latency and credit consumption
        do_reset();
        check_reset_vals("post_rel");
        push_tx(20'h12345);
        bus.pe_tx_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_vo", 32'(bus.net_vo), 32'd0);
        cyc();
        @(negedge clk);
        check("lat_n2_vo", 32'(bus.net_vo), 32'd1);
        check("lat_n2_o", 32'(bus.net_o), 32'h12345);
        check("first_tx_count", 32'(bus.tx_count), 32'd1);
        check("first_credits", 32'(credit_count), 32'd3);
        cyc();
        bus.net_ci = 1'b1;
        cyc();
        bus.net_ci = 1'b0;
        @(negedge clk);
        check("credit_back", 32'(credit_count), 32'd4);

        // Credit exhaustion: 6 writes, only 4 sends, inject FIFO fills
        cyc();
        n0 = net_pulses;
        for (int i = 0; i < 6; i++) push_tx(20'hA0000 + 20'(i));
        bus.pe_tx_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("exhaust_pulses", 32'(net_pulses - n0), 32'd4);
        check("exhaust_credits", 32'(credit_count), 32'd0);
        check("exhaust_ready_2", 32'(bus.pe_tx_ready), 32'd1);
        cyc();
        push_tx(20'hA0006);
        push_tx(20'hA0007);
        bus.pe_tx_valid = 1'b0;
        @(negedge clk);
        check("exhaust_ready_full", 32'(bus.pe_tx_ready), 32'd0);
        cyc();
        bus.net_ci = 1'b1;
        cyc();
        bus.net_ci = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("one_credit_one_send", 32'(net_pulses - n0), 32'd5);
        cyc();
        for (int i = 0; i < 7; i++) begin
            bus.net_ci = 1'b1;
            cyc();
        end
        bus.net_ci = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("drain_pulses", 32'(net_pulses - n0), 32'd8);
        check("drain_credits", 32'(credit_count), 32'd4);
        check("drain_net_q", 32'(exp_net_q.size()), 32'd0);

        // Credit return coincident with a send, and saturation
        cyc();
        push_tx(20'hB0000);
        push_tx(20'hB0001);
        bus.pe_tx_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("coinc_pre_credits", 32'(credit_count), 32'd2);
        cyc();
        push_tx(20'hB0002);
        bus.pe_tx_valid = 1'b0;
        bus.net_ci      = 1'b1;
        cyc();
        bus.net_ci = 1'b0;
        @(negedge clk);
        check("coinc_vo", 32'(bus.net_vo), 32'd1);
        check("coinc_credits", 32'(credit_count), 32'd2);
        cyc();
        bus.net_ci = 1'b1;
        cyc();
        cyc();
        bus.net_ci = 1'b0;
        @(negedge clk);
        check("refill_credits", 32'(credit_count), 32'd4);
        cyc();
        bus.net_ci = 1'b1;
        cyc();
        bus.net_ci = 1'b0;
        @(negedge clk);
        check("sat_credits", 32'(credit_count), 32'd4);

        // Full eject FIFO with same-cycle pop accepts the new flit
        cyc();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            bus.net_i  = 20'h00100 + 20'(i);
            bus.net_vi = 1'b1;
            exp_rx_q.push_back(bus.net_i);
            cyc();
        end
        bus.net_i       = 20'h00200;
        bus.pe_rx_ready = 1'b1;
        exp_rx_q.push_back(20'h00200);
        cyc();
        bus.net_vi      = 1'b0;
        bus.pe_rx_ready = 1'b0;
        @(negedge clk);
        check("fullpop_overflow", 32'(bus.overflow), 32'd0);
        check("fullpop_rx_count", 32'(bus.rx_count), 32'd5);
        check("fullpop_head", 32'(bus.pe_rx_flit), 32'h00102);
        cyc();
        bus.pe_rx_ready = 1'b1;
        repeat (5) cyc();
        bus.pe_rx_ready = 1'b0;
        @(negedge clk);
        check("fullpop_drained", 32'(bus.pe_rx_valid), 32'd0);
        check("fullpop_rx_q", 32'(exp_rx_q.size()), 32'd0);

        // Eject overflow: 5 flits with PE stalled, fifth is dropped
        cyc();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.net_i  = 20'(i);
            bus.net_vi = 1'b1;
            if (i <= 4) exp_rx_q.push_back(20'(i));
            cyc();
        end
        bus.net_vi = 1'b0;
        @(negedge clk);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_rx_count", 32'(bus.rx_count), 32'd4);
        check("ovf_head", 32'(bus.pe_rx_flit), 32'h00001);
        check("ovf_valid", 32'(bus.pe_rx_valid), 32'd1);
        c0 = co_pulses;
        cyc();
        bus.pe_rx_ready = 1'b1;
        repeat (4) cyc();
        bus.pe_rx_ready = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        check("ovf_co_pulses", 32'(co_pulses - c0), 32'd4);
        check("ovf_drained", 32'(bus.pe_rx_valid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // tx_count wraps after 65536 sends
        cyc();
        do_reset();
        bus.net_ci = 1'b1;
        for (int i = 0; i < 65535; i++) push_tx(20'(i));
        bus.pe_tx_valid = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        check("wrap_pre", 32'(bus.tx_count), 32'h0000FFFF);
        check("wrap_pre_q", 32'(exp_net_q.size()), 32'd0);
        cyc();
        push_tx(20'h5A5A5);
        bus.pe_tx_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("wrap_post", 32'(bus.tx_count), 32'd0);
        cyc();
        bus.net_ci = 1'b0;

        // Mid-operation reset discards buffered flits and pending pulses
        for (int i = 0; i < 3; i++) begin
            bus.net_i  = 20'hC0000 + 20'(i);
            bus.net_vi = 1'b1;
            cyc();
        end
        bus.net_vi = 1'b0;
        push_tx(20'h77777);
        bus.pe_tx_valid = 1'b0;
        rst = 1'b0;
        exp_net_q.delete();
        exp_rx_q.delete();
        n0 = net_pulses;
        c0 = co_pulses;
        #1;
        check_reset_vals("midrst");
        cyc();
        rst = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        check_reset_vals("after_midrst");
        check("midrst_no_vo", 32'(net_pulses - n0), 32'd0);
        check("midrst_no_co", 32'(co_pulses - c0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
